// File: rtl/bk_sector_seq_if.sv
`default_nettype none
// ============================================================================
// bk_sector_seq_if : HPS SD-sector request/acknowledge bundle.
// Rev 1.0
// ============================================================================
interface bk_sector_seq_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;

  modport master (output sd_lba, sd_rd, sd_wr, input sd_ack);
  modport slave  (input sd_lba, sd_rd, sd_wr, output sd_ack);
endinterface
`default_nettype wire

// File: rtl/bk_sector_seq.sv
`default_nettype none
// ============================================================================
// bk_sector_seq : backup-RAM save/load/format sequencer (optional: BK_AUTOLOAD_EN)
// Rev 1.0
// ============================================================================
module bk_sector_seq #(
  parameter int SECTORS = 16,
  parameter int SEC_W   = $clog2(SECTORS)
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    download,
  input  logic                    img_mounted,
  input  logic                    img_readonly,
  input  logic                    img_size_nz,
  input  logic                    bk_load,
  input  logic                    bk_save,
  input  logic [1:0]              slot,
  input  logic                    format,
  bk_sector_seq_if.master         sd_bus,
  output logic                    bk_ena,
  output logic                    busy,
  output logic                    loading,
  output logic                    fmt_we,
  output logic [1:0]              fmt_addr,
  output logic [15:0]             fmt_data
);

`ifdef BK_AUTOLOAD_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd1, S_FMT = 2'd2, S_ARM = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd1, S_FMT = 2'd2} state_t;
`endif

  state_t      r_state, w_state_nxt;
  logic        r_dl_d, r_load_d, r_save_d, r_fmt_d, r_ack_d;
  logic        r_bk_ena;
  logic [31:0] r_lba, w_lba_nxt;
  logic        r_rd, w_rd_nxt;
  logic        r_wr, w_wr_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_loading, w_loading_nxt;
  logic        r_fmt_we, w_fmt_we_nxt;
  logic [1:0]  r_fmt_addr, w_fmt_addr_nxt;
  logic [15:0] r_fmt_data, w_fmt_data_nxt;

  logic        w_dl_rise, w_load_rise, w_save_rise, w_fmt_rise, w_ack_rise, w_ack_fall;
  logic        w_ena_set, w_req, w_last;
  logic [31:0] w_slot_base;
  logic        w_go, w_go_ld;
  logic [31:0] w_go_lba;

  function automatic logic [15:0] fmt_word(input logic [1:0] a);
    case (a)
      2'd0:    fmt_word = 16'h5548;
      2'd1:    fmt_word = 16'h4D42;
      2'd2:    fmt_word = 16'h8800;
      default: fmt_word = 16'h8010;
    endcase
  endfunction

  assign w_dl_rise   = download & ~r_dl_d;
  assign w_load_rise = bk_load & ~r_load_d;
  assign w_save_rise = bk_save & ~r_save_d;
  assign w_fmt_rise  = format & ~r_fmt_d;
  assign w_ack_rise  = sd_bus.sd_ack & ~r_ack_d;
  assign w_ack_fall  = ~sd_bus.sd_ack & r_ack_d;
  assign w_ena_set   = download & img_mounted & img_size_nz & ~img_readonly;
  assign w_req       = r_bk_ena & (w_load_rise | w_save_rise);
  assign w_slot_base = {{(30 - SEC_W){1'b0}}, slot, {SEC_W{1'b0}}};
  // Last sector of a slot is the all-ones index, so the slot field never carries.
  assign w_last      = &r_lba[SEC_W-1:0];

`ifdef BK_AUTOLOAD_EN
  logic r_ena_d;
  logic w_ena_rise;
  assign w_ena_rise = r_bk_ena & ~r_ena_d;
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_ena_d <= 1'b0;
    else          r_ena_d <= r_bk_ena;
  end
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_dl_d     <= 1'b0;
      r_load_d   <= 1'b0;
      r_save_d   <= 1'b0;
      r_fmt_d    <= 1'b0;
      r_ack_d    <= 1'b0;
      r_bk_ena   <= 1'b0;
      r_lba      <= 32'd0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_busy     <= 1'b0;
      r_loading  <= 1'b0;
      r_fmt_we   <= 1'b0;
      r_fmt_addr <= 2'd0;
      r_fmt_data <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_dl_d     <= download;
      r_load_d   <= bk_load;
      r_save_d   <= bk_save;
      r_fmt_d    <= format;
      r_ack_d    <= sd_bus.sd_ack;
      if (w_ena_set)      r_bk_ena <= 1'b1;
      else if (w_dl_rise) r_bk_ena <= 1'b0;
      r_lba      <= w_lba_nxt;
      r_rd       <= w_rd_nxt;
      r_wr       <= w_wr_nxt;
      r_busy     <= w_busy_nxt;
      r_loading  <= w_loading_nxt;
      r_fmt_we   <= w_fmt_we_nxt;
      r_fmt_addr <= w_fmt_addr_nxt;
      r_fmt_data <= w_fmt_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_lba_nxt      = r_lba;
    w_rd_nxt       = r_rd;
    w_wr_nxt       = r_wr;
    w_busy_nxt     = r_busy;
    w_loading_nxt  = r_loading;
    w_fmt_we_nxt   = r_fmt_we;
    w_fmt_addr_nxt = r_fmt_addr;
    w_fmt_data_nxt = r_fmt_data;
    w_go           = 1'b0;
    w_go_ld        = 1'b0;
    w_go_lba       = w_slot_base;

    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_go    = 1'b1;
          w_go_ld = bk_load;
        end else if (w_fmt_rise) begin
          w_state_nxt    = S_FMT;
          w_fmt_we_nxt   = 1'b1;
          w_fmt_addr_nxt = 2'd0;
          w_fmt_data_nxt = fmt_word(2'd0);
        end
`ifdef BK_AUTOLOAD_EN
        else if (w_ena_rise) begin
          w_state_nxt = S_ARM;
        end
`endif
      end
      S_XFER: begin
        if (w_ack_rise) begin
          w_rd_nxt = 1'b0;
          w_wr_nxt = 1'b0;
        end
        if (w_ack_fall) begin
          if (w_last) begin
            w_state_nxt   = S_IDLE;
            w_busy_nxt    = 1'b0;
            w_loading_nxt = 1'b0;
          end else begin
            w_lba_nxt = r_lba + 32'd1;
            w_rd_nxt  = r_loading;
            w_wr_nxt  = ~r_loading;
          end
        end
      end
      S_FMT: begin
        if (r_fmt_addr == 2'd3) begin
          w_state_nxt  = S_IDLE;
          w_fmt_we_nxt = 1'b0;
        end else begin
          w_fmt_addr_nxt = r_fmt_addr + 2'd1;
          w_fmt_data_nxt = fmt_word(r_fmt_addr + 2'd1);
        end
      end
`ifdef BK_AUTOLOAD_EN
      S_ARM: begin
        if (w_req) begin
          w_go    = 1'b1;
          w_go_ld = bk_load;
        end else if (!download) begin
          w_go     = 1'b1;
          w_go_ld  = 1'b1;
          w_go_lba = 32'd0;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_go) begin
      w_state_nxt   = S_XFER;
      w_lba_nxt     = w_go_lba;
      w_loading_nxt = w_go_ld;
      w_rd_nxt      = w_go_ld;
      w_wr_nxt      = ~w_go_ld;
      w_busy_nxt    = 1'b1;
    end
  end

  assign sd_bus.sd_lba = r_lba;
  assign sd_bus.sd_rd  = r_rd;
  assign sd_bus.sd_wr  = r_wr;
  assign bk_ena        = r_bk_ena;
  assign busy          = r_busy;
  assign loading       = r_loading;
  assign fmt_we        = r_fmt_we;
  assign fmt_addr      = r_fmt_addr;
  assign fmt_data      = r_fmt_data;

endmodule
`default_nettype wire

// File: tb/tb_bk_sector_seq.sv
`default_nettype none
// ============================================================================
// tb_bk_sector_seq : randomized bench with a transaction-level HPS/RAM model.
// Rev 1.0
// ============================================================================
module tb_bk_sector_seq;
  localparam int SECTORS = 16;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        download = 1'b0, img_mounted = 1'b0, img_readonly = 1'b0, img_size_nz = 1'b0;
  logic        bk_load = 1'b0, bk_save = 1'b0, format = 1'b0;
  logic [1:0]  slot = 2'd0;
  logic        bk_ena, busy, loading, fmt_we;
  logic [1:0]  fmt_addr;
  logic [15:0] fmt_data;

  int n_checks = 0, n_errors = 0, fmt_seen = 0, rd_seen = 0;
  logic [15:0] fmt_ref [4] = '{16'h5548, 16'h4D42, 16'h8800, 16'h8010};

  always #5 clk_sys = ~clk_sys;

  bk_sector_seq_if bus ();
  initial bus.sd_ack = 1'b0;

  bk_sector_seq #(.SECTORS(SECTORS)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .download(download),
    .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size_nz(img_size_nz),
    .bk_load(bk_load), .bk_save(bk_save), .slot(slot), .format(format),
    .sd_bus(bus.master), .bk_ena(bk_ena), .busy(busy), .loading(loading),
    .fmt_we(fmt_we), .fmt_addr(fmt_addr), .fmt_data(fmt_data)
  );

  always begin
    @(negedge clk_sys); #1;
    if (fmt_we) fmt_seen++;
    if (bus.sd_rd) rd_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // HPS side: expects nsec consecutive sectors of the slot, random ack timing.
  task automatic hps_xfer(input bit ld, input logic [1:0] sl, input int nsec);
    int n;
    int fmt0;
    fmt0 = fmt_seen;
    for (int s = 0; s < nsec; s++) begin
      n = 0;
      while (!(bus.sd_rd || bus.sd_wr) && n < 20) begin tick(1); n++; end
      chk("req_latency", n, 0);
      chk("lba", bus.sd_lba, sl * SECTORS + s);
      chk("rd", bus.sd_rd, ld);
      chk("wr", bus.sd_wr, !ld);
      chk("busy", busy, 1);
      chk("loading", loading, ld);
      tick($urandom_range(0, 2));
      if (s == 3) format = 1'b1;
      bus.sd_ack = 1'b1;
      tick(1);
      format = 1'b0;
      chk("req_drop_on_ack", bus.sd_rd | bus.sd_wr, 0);
      tick($urandom_range(0, 3));
      bus.sd_ack = 1'b0;
      tick(1);
    end
    if (nsec == SECTORS) begin
      chk("busy_end", busy, 0);
      chk("loading_end", loading, 0);
      chk("rdwr_end", bus.sd_rd | bus.sd_wr, 0);
      tick(2);
      chk("fmt_during_xfer", fmt_seen - fmt0, 0);
    end
  endtask

  task automatic mount(input bit ro);
    download = 1'b1;
    tick(2);
    img_mounted = 1'b1; img_readonly = ro; img_size_nz = 1'b1;
    tick(1);
    img_mounted = 1'b0; img_readonly = 1'b0;
    tick(1);
    chk("bk_ena_mount", bk_ena, !ro);
    download = 1'b0;
    tick(1);
`ifdef BK_AUTOLOAD_EN
    if (!ro) hps_xfer(1'b1, 2'd0, SECTORS);
`endif
  endtask

  task automatic request(input bit ld, input bit sv, input logic [1:0] sl);
    slot = sl; bk_load = ld; bk_save = sv;
    tick(1);
    bk_load = 1'b0; bk_save = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_lba"}, bus.sd_lba, 0);
    chk({tag, "_rdwr"}, {bus.sd_rd, bus.sd_wr}, 0);
    chk({tag, "_bk_ena"}, bk_ena, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_loading"}, loading, 0);
    chk({tag, "_fmt"}, {fmt_we, fmt_addr, fmt_data}, 0);
  endtask

  initial begin
    int r0, f0;
    logic [1:0] sl;
    bit ld;

    tick(2);
    check_reset_values("reset");
    reset_n = 1'b1;
    tick(1);

    mount(1'b0);

    r0 = rd_seen;
    request(1'b0, 1'b1, 2'd2);
    hps_xfer(1'b0, 2'd2, SECTORS);
    chk("rd_during_save", rd_seen - r0, 0);

    request(1'b1, 1'b0, 2'd1);
    hps_xfer(1'b1, 2'd1, SECTORS);

    for (int i = 0; i < 4; i++) begin
      ld = 1'($urandom_range(0, 1));
      sl = 2'($urandom_range(0, 3));
      tick($urandom_range(1, 4));
      request(ld, !ld, sl);
      hps_xfer(ld, sl, SECTORS);
    end

    sl = 2'($urandom_range(0, 3));
    request(1'b1, 1'b1, sl);
    hps_xfer(1'b1, sl, SECTORS);

    f0 = fmt_seen;
    format = 1'b1;
    request(1'b0, 1'b1, 2'd3);
    format = 1'b0;
    hps_xfer(1'b0, 2'd3, SECTORS);
    chk("fmt_vs_req_same_cycle", fmt_seen - f0, 0);

    format = 1'b1;
    tick(1);
    for (int a = 0; a < 4; a++) begin
      chk("fmt_we", fmt_we, 1);
      chk("fmt_addr", fmt_addr, a);
      chk("fmt_data", fmt_data, fmt_ref[a]);
      tick(1);
    end
    chk("fmt_we_done", fmt_we, 0);
    format = 1'b0;
    tick(2);
    request(1'b1, 1'b0, 2'd0);
    hps_xfer(1'b1, 2'd0, SECTORS);

    mount(1'b1);
    r0 = rd_seen;
    request(1'b1, 1'b0, 2'd1);
    tick(4);
    chk("ro_busy", busy, 0);
    chk("ro_rd", rd_seen - r0, 0);

    mount(1'b0);
    sl = 2'($urandom_range(0, 3));
    request(1'b1, 1'b0, sl);
    hps_xfer(1'b1, sl, 5);
    reset_n = 1'b0;
    #1;
    check_reset_values("midload_reset");
    tick(1);
    reset_n = 1'b1;
    tick(1);
    mount(1'b0);
    request(1'b0, 1'b1, 2'd3);
    hps_xfer(1'b0, 2'd3, SECTORS);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
